fetch_queue: RTL and testbench

//  Fetch-stage front end between Instruction_Memory and the IF_ID pipeline register.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 138 +++++++++++++
 tb/tb_fetch_queue.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the fetch front end
package cpu_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // IDLE: no request, WAIT: request outstanding, DROP: outstanding response to discard
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FIFO of {pc, instr} pairs with synchronous clear
//
// Ports:
//   clk        clock
//   resetn     synchronous reset, active-low
//   clear      drop all entries at the next edge (wins over push/pop)
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        advance the head (ignored when empty)
//   head_data  entry at the head (contents undefined when empty)
//   count      number of valid entries, 0..DEPTH
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_eff;

    assign pop_eff   = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (resetn && !clear && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop_eff);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC owner, instruction-memory requester and IF_ID feed queue
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active-low
//   start_i        fetch enable; an outstanding request still completes when low
//   imem_req_o     request valid, held with imem_addr_o until imem_ack_i
//   imem_addr_o    word-aligned fetch address
//   imem_ack_i     response valid, same cycle as imem_instr_i
//   imem_instr_i   instruction word for the outstanding request
//   redirect_i     taken branch/jump; flushes the queue and refetches from redirect_pc_i
//   redirect_pc_i  redirect target, bits [1:0] forced to zero
//   stall_i        IF_ID stall; head is held
//   valid_o        queue non-empty
//   pc_o           PC of the head entry (0 when empty)
//   instr_o        instruction of the head entry (NOP when empty)
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP      = NOP_INSTR
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_instr_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o
);

    localparam int              CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t       state;
    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    fetch_pc_inc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_after;
    logic [2*XLEN-1:0]  head_data;
    logic               push;
    logic               pop;

    // A redirect kills both the pending response and the head consume.
    assign push         = (state == WAIT) && imem_ack_i && !redirect_i;
    assign pop          = valid_o && !stall_i && !redirect_i;
    assign fetch_pc_inc = fetch_pc + 32'd4;

    // Occupancy once this cycle's push/pop settle; used to decide a back-to-back issue.
    always_comb begin
        count_after = count + CNT_W'(push) - CNT_W'(pop);
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk       (clk_i),
        .resetn    (rst_i),
        .clear     (redirect_i),
        .push      (push),
        .push_data ({imem_addr_o, imem_instr_i}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    // Head outputs come straight from FIFO registers; nothing from imem_* reaches them.
    assign valid_o = (count != '0);
    assign pc_o    = valid_o ? head_data[2*XLEN-1:XLEN] : '0;
    assign instr_o = valid_o ? head_data[XLEN-1:0]      : NOP;

    // Issue rule reserves a queue slot for the outstanding word, so a push never
    // lands in a full queue.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
            case (state)
                WAIT, DROP: begin
                    if (imem_ack_i) begin
                        state      <= IDLE;
                        imem_req_o <= 1'b0;
                    end else begin
                        state <= DROP;
                    end
                end
                default: begin
                    state      <= IDLE;
                    imem_req_o <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && (count < DEPTH_C)) begin
                        state       <= WAIT;
                        imem_req_o  <= 1'b1;
                        imem_addr_o <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (imem_ack_i) begin
                        fetch_pc <= fetch_pc_inc;
                        if (start_i && (count_after < DEPTH_C)) begin
                            imem_addr_o <= fetch_pc_inc;
                        end else begin
                            state      <= IDLE;
                            imem_req_o <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack_i) begin
                        state      <= IDLE;
                        imem_req_o <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    imem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_instr;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;

    int          checks = 0;
    int          errors = 0;
    int          consumed = 0;
    int          lat = 1;
    int          wait_cnt = 0;
    logic        stray_ack = 1'b0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_q[$];

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .NOP      (32'h0000_0013)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_instr_i  (imem_instr),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .stall_i       (stall),
        .valid_o       (valid),
        .pc_o          (pc),
        .instr_o       (instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
    endfunction

    // Memory: acks once a request has been held for lat cycles.
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    always_comb begin
        imem_ack   = (imem_req && (wait_cnt == lat)) || stray_ack;
        imem_instr = mem_f(imem_addr);
    end

    // Scoreboard: every consumed head must be the next expected PC in order.
    always @(negedge clk) begin
        if (mon_en && rst && valid && !stall && !redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL head_extra got pc=%h expected none", pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (pc !== e || instr !== mem_f(e)) begin
                    errors++;
                    $display("FAIL head_entry got pc=%h instr=%h expected pc=%h instr=%h",
                             pc, instr, e, mem_f(e));
                end
                consumed++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stream(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_consumed(input int target, input string name);
        int cyc = 0;
        while (consumed < target && cyc < 400) begin
            step();
            cyc++;
        end
        checks++;
        if (consumed < target) begin
            errors++;
            $display("FAIL %s_progress got %0d consumed expected %0d", name, consumed, target);
        end
    endtask

    task automatic wait_valid(input logic [31:0] exp_pc, input string name);
        int cyc = 0;
        while (!valid && cyc < 60) begin
            step();
            cyc++;
        end
        checks++;
        if (!valid || pc !== exp_pc) begin
            errors++;
            $display("FAIL %s_first got valid=%b pc=%h expected valid=1 pc=%h", name, valid, pc, exp_pc);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0;
        step(); step();
        checks += 4;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b expected 0", imem_req); end
        if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b expected 0", valid); end
        if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h expected 0", pc); end
        if (instr !== 32'h13) begin errors++; $display("FAIL rst_instr got %h expected 00000013", instr); end
    endtask

    task automatic test_stream();
        lat = 1;
        set_stream(32'h0);
        mon_en = 1'b1;
        rst = 1'b1; start = 1'b1;
        step();
        checks += 2;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL stream_issue got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
        end
        if (valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid got %b expected 0", valid); end
        step();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL stream_c2_valid got %b expected 0", valid); end
        step();
        checks++;
        if (valid !== 1'b1 || pc !== 32'h0 || instr !== mem_f(32'h0)) begin
            errors++;
            $display("FAIL stream_c3_head got valid=%b pc=%h instr=%h expected 1 0 %h", valid, pc, instr, mem_f(32'h0));
        end
        wait_consumed(consumed + 8, "stream");
    endtask

    task automatic test_stall();
        logic late_req = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 8 && imem_req) late_req = 1'b1;
        end
        checks += 2;
        if (late_req !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_req got %b expected 0", imem_req);
        end
        if (valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b expected 1", valid); end
        stall = 1'b0;
        wait_consumed(consumed + 10, "stall");
    endtask

    task automatic test_redirect_drop();
        bit found = 0;
        pulse_reset();
        set_stream(32'h0);
        lat = 3;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (imem_req && imem_addr == 32'h8 && !imem_ack) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL drop_find got none expected req addr=00000008"); end
        redirect = 1'b1; redirect_pc = 32'h100;
        set_stream(32'h100);
        step();
        redirect = 1'b0;
        checks += 2;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL drop_hold got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr);
        end
        if (valid !== 1'b0) begin errors++; $display("FAIL drop_flush got valid=%b expected 0", valid); end
        wait_valid(32'h100, "drop");
        wait_consumed(consumed + 4, "drop");
    endtask

    task automatic test_redirect_stall();
        lat = 1;
        stall = 1'b1;
        step(); step(); step(); step();
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL rs_pre got valid=%b expected 1", valid); end
        redirect = 1'b1; redirect_pc = 32'h200;
        set_stream(32'h200);
        step();
        redirect = 1'b0;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL rs_flush got valid=%b expected 0", valid); end
        stall = 1'b0;
        wait_valid(32'h200, "rs");
        wait_consumed(consumed + 4, "rs");
    endtask

    task automatic test_redirect_ack();
        bit found = 0;
        lat = 2;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (imem_ack) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL ra_find got none expected ack"); end
        redirect = 1'b1; redirect_pc = 32'h300;
        set_stream(32'h300);
        step();
        redirect = 1'b0;
        checks += 2;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL ra_idle got req=%b expected 0", imem_req); end
        if (valid !== 1'b0) begin errors++; $display("FAIL ra_flush got valid=%b expected 0", valid); end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            errors++; $display("FAIL ra_issue got req=%b addr=%h expected req=1 addr=00000300", imem_req, imem_addr);
        end
        wait_consumed(consumed + 4, "ra");
    endtask

    task automatic test_reset_midwait();
        bit found = 0;
        lat = 5;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (imem_req && wait_cnt == 1) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rm_find got none expected outstanding req"); end
        rst = 1'b0; start = 1'b0;
        set_stream(32'h0);
        step();
        rst = 1'b1;
        checks += 2;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req got %b expected 0", imem_req); end
        if (valid !== 1'b0 || pc !== 32'h0) begin
            errors++; $display("FAIL rm_valid got valid=%b pc=%h expected 0 0", valid, pc);
        end
        stray_ack = 1'b1;
        step();
        stray_ack = 1'b0;
        step();
        checks++;
        if (valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL rm_late_ack got valid=%b req=%b expected 0 0", valid, imem_req);
        end
        start = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL rm_refetch got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
        end
        wait_consumed(consumed + 3, "rm");
    endtask

    task automatic test_wrap();
        bit found = 0;
        lat = 1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        set_stream(32'hFFFF_FFFC);
        step();
        redirect = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req && imem_addr == 32'hFFFF_FFFC) found = 1;
            else step();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL wrap_issue got addr=%h expected fffffffc", imem_addr); end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (imem_req && imem_addr != 32'hFFFF_FFFC) found = 1;
        end
        checks++;
        if (!found || imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_next got addr=%h expected 00000000", imem_addr);
        end
        wait_consumed(consumed + 4, "wrap");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_stall();
        test_redirect_ack();
        test_reset_midwait();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
